// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises a latched word as start bit, LSB-first data,
// optional even/odd parity and one stop bit, with an internal bit-rate prescaler.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic [2:0]            dbg_state_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         pre_cnt_q, pre_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  bit_end;
    logic [BW-1:0]         bit_nxt;
    logic                  par_bit;

    assign bit_end = (pre_cnt_q == PRE_LAST);
    assign bit_nxt = bit_cnt_q + 1'b1;
    // Parity comes only from the latched copy, so mid-frame input changes are harmless.
    assign par_bit = (^data_q) ^ par_typ_q;

    // Each output is computed one cycle early so TX_OUT/Busy come straight from flops.
    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (Data_Valid) begin
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    pre_cnt_d = '0;
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    pre_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                    tx_d      = data_q[0];
                end else begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    pre_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_nxt;
                        tx_d      = data_q[bit_nxt];
                    end
                end else begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    pre_cnt_d = '0;
                    state_d   = STOP;
                    tx_d      = 1'b1;
                end else begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    pre_cnt_d = '0;
                    state_d   = IDLE;
                    tx_d      = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            pre_cnt_q <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT      = tx_q;
    assign Busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: one instance at PRESCALE=1 and one at PRESCALE=4, with
// per-cycle expected line images queued at stimulus time and checked by frame monitors.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] p_data = 8'hFF;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       dv1 = 1'b1;
    logic       dv4 = 1'b1;
    logic       tx1, busy1, tx4, busy4;
    logic [2:0] st1, st4;

    int vec_cnt = 0;
    int err_cnt = 0;
    bit mon_en  = 1'b0;

    // Line image per frame: bit i is TX_OUT in the i-th busy cycle.
    logic [63:0] exp_q1[$];
    int          exp_len1[$];
    logic [63:0] exp_q4[$];
    int          exp_len4[$];

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE(1)) u_dut1 (
        .CLK(clk), .RST(rst), .P_DATA(p_data), .Data_Valid(dv1),
        .PAR_EN(par_en), .PAR_TYP(par_typ),
        .TX_OUT(tx1), .Busy(busy1), .dbg_state_o(st1)
    );

    uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE(4)) u_dut4 (
        .CLK(clk), .RST(rst), .P_DATA(p_data), .Data_Valid(dv4),
        .PAR_EN(par_en), .PAR_TYP(par_typ),
        .TX_OUT(tx4), .Busy(busy4), .dbg_state_o(st4)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] expand(input logic [15:0] bits, input int n, input int p);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < p; j++)
                r[i*p+j] = bits[i];
        return r;
    endfunction

    task automatic push1(input int len, input logic [63:0] bits);
        exp_len1.push_back(len);
        exp_q1.push_back(bits);
    endtask

    task automatic push4(input int len, input logic [63:0] bits);
        exp_len4.push_back(len);
        exp_q4.push_back(bits);
    endtask

    // Monitor for the PRESCALE=1 instance.
    logic [63:0] cur1 = '0;
    int          len1 = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy1 === 1'b1) begin
                if (len1 < 64) cur1[len1] = tx1;
                len1++;
            end else begin
                if (len1 > 0) begin
                    if (exp_len1.size() == 0) begin
                        vec_cnt++;
                        err_cnt++;
                        $display("FAIL frame1_unexpected: got frame len %0d bits %0h expected none", len1, cur1);
                    end else begin
                        chk("frame1_len", 64'(len1), 64'(exp_len1.pop_front()));
                        chk("frame1_bits", cur1, exp_q1.pop_front());
                    end
                    len1 = 0;
                    cur1 = '0;
                end
                chk("idle1_tx", {63'd0, tx1}, 64'd1);
            end
        end
    end

    // Monitor for the PRESCALE=4 instance.
    logic [63:0] cur4 = '0;
    int          len4 = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy4 === 1'b1) begin
                if (len4 < 64) cur4[len4] = tx4;
                len4++;
            end else begin
                if (len4 > 0) begin
                    if (exp_len4.size() == 0) begin
                        vec_cnt++;
                        err_cnt++;
                        $display("FAIL frame4_unexpected: got frame len %0d bits %0h expected none", len4, cur4);
                    end else begin
                        chk("frame4_len", 64'(len4), 64'(exp_len4.pop_front()));
                        chk("frame4_bits", cur4, exp_q4.pop_front());
                    end
                    len4 = 0;
                    cur4 = '0;
                end
                chk("idle4_tx", {63'd0, tx4}, 64'd1);
            end
        end
    end

    task automatic send1(input logic [7:0] d, input logic pe, input logic pt);
        @(posedge clk); #1;
        p_data = d; par_en = pe; par_typ = pt; dv1 = 1'b1;
        @(posedge clk); #1;
        dv1 = 1'b0;
    endtask

    task automatic send4(input logic [7:0] d, input logic pe, input logic pt);
        @(posedge clk); #1;
        p_data = d; par_en = pe; par_typ = pt; dv4 = 1'b1;
        @(posedge clk); #1;
        dv4 = 1'b0;
    endtask

    // Waits at negedges until the chosen instance's Busy equals lvl, within a budget.
    task automatic wait_busy(input int which, input logic lvl, input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (((which == 1) ? busy1 : busy4) === lvl) return;
        end
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s_timeout: got no Busy=%0b expected within 300 cycles", name, lvl);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int gap;

        // Reset held for two edges with Data_Valid high: nothing may start.
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_busy1_a", {63'd0, busy1}, 64'd0);
        chk("rst_tx1_a", {63'd0, tx1}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0; dv1 = 1'b0; dv4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_busy1", {63'd0, busy1}, 64'd0);
            chk("post_rst_busy4", {63'd0, busy4}, 64'd0);
        end

        // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1.
        push1(11, 64'b1_0_10100101_0);
        send1(8'hA5, 1'b1, 1'b0);
        wait_busy(1, 1'b0, "a5");

        // 0x01 odd parity: parity bit 0.
        push1(11, 64'b1_0_00000001_0);
        send1(8'h01, 1'b1, 1'b1);
        wait_busy(1, 1'b0, "01odd");

        // 0x03 without parity: 0,1,1,0,0,0,0,0,0,1.
        push1(10, 64'b1_00000011_0);
        send1(8'h03, 1'b0, 1'b0);
        wait_busy(1, 1'b0, "03nopar");

        // 0x00 with a 0xFF request pulsed mid-frame that must be ignored.
        push1(10, 64'b1_00000000_0);
        send1(8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        p_data = 8'hFF; par_en = 1'b1; dv1 = 1'b1;
        @(posedge clk); #1;
        dv1 = 1'b0; p_data = 8'h00; par_en = 1'b0;
        wait_busy(1, 1'b0, "ignore");
        repeat (15) @(negedge clk);
        chk("no_extra_frame", {63'd0, busy1}, 64'd0);

        // Back-to-back with Data_Valid held high; inputs change mid-frame.
        push1(10, 64'b1_01011010_0);
        push1(10, 64'b1_10010110_0);
        @(posedge clk); #1;
        p_data = 8'h5A; par_en = 1'b0; par_typ = 1'b0; dv1 = 1'b1;
        wait_busy(1, 1'b1, "b2b_first");
        p_data = 8'h96; par_en = 1'b1; par_typ = 1'b1;
        repeat (3) @(negedge clk);
        par_en = 1'b0; par_typ = 1'b0;
        wait_busy(1, 1'b0, "b2b_end1");
        gap = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy1) break;
            gap++;
        end
        chk("b2b_gap", 64'(gap), 64'd1);
        dv1 = 1'b0;
        wait_busy(1, 1'b0, "b2b_end2");
        repeat (15) @(negedge clk);
        chk("b2b_no_third", {63'd0, busy1}, 64'd0);

        // Reset during data bit 3 of 0x0F: partial image start,1,1,1,1.
        push1(5, 64'b11110);
        send1(8'h0F, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {63'd0, busy1}, 64'd0);
        chk("midrst_tx", {63'd0, tx1}, 64'd1);
        repeat (5) @(negedge clk);
        chk("midrst_no_resume", {63'd0, busy1}, 64'd0);

        // Complete frame after the abort: 0xC3 even parity, parity bit 0.
        push1(11, 64'b1_0_11000011_0);
        send1(8'hC3, 1'b1, 1'b0);
        wait_busy(1, 1'b0, "c3");

        // PRESCALE=4: 0x80 without parity, MSB high in cycles 32..35.
        push4(40, expand(16'b1_10000000_0, 10, 4));
        send4(8'h80, 1'b0, 1'b0);
        wait_busy(4, 1'b0, "p4_80");

        // PRESCALE=4: 0x6B odd parity (5 ones, parity bit 0).
        push4(44, expand(16'b1_0_01101011_0, 11, 4));
        send4(8'h6B, 1'b1, 1'b1);
        wait_busy(4, 1'b0, "p4_6b");

        repeat (30) @(negedge clk);
        chk("queue1_drained", 64'(exp_len1.size()), 64'd0);
        chk("queue4_drained", 64'(exp_len4.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Transmit side of the UART link: accepts a parallel byte from the system side with a valid strobe and serialises it onto the line as a start bit, LSB-first data bits, an optional parity bit and one stop bit. It drives the line idle-high, reports `Busy` for the whole frame, and generates its own bit timing with an internal prescale counter. It is the transmit counterpart of the receive chain's start/parity/stop checkers, and its frame format matches theirs bit for bit.

## Interface
- `DATA_WIDTH`, 8: width of the payload word; at least 5.
- `PRESCALE`, 1: `CLK` cycles per serial bit; at least 1.
- `CLK` input 1: single clock. All logic is rising-edge.
- `RST` input 1: synchronous, active-high reset.
- `P_DATA` input `DATA_WIDTH`: payload to transmit.
- `Data_Valid` input 1: request strobe. A request is accepted only in a cycle where `Busy` = 0.
- `PAR_EN` input 1: 1 inserts a parity bit after the data bits.
- `PAR_TYP` input 1: 0 selects even parity, 1 selects odd parity.
- `TX_OUT` output 1: serial line; idles at 1.
- `Busy` output 1: high from the first start-bit cycle through the last stop-bit cycle.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - `pre_cnt` counts 0..PRESCALE-1; it reaches the end of a bit at PRESCALE-1.
  - `bit_cnt` counts 0..DATA_WIDTH-1.
- IDLE
  - `TX_OUT`=1 and `Busy`=0.
  - If `Data_Valid`=1, latch `P_DATA`, `PAR_EN` and `PAR_TYP`, then go to START.
  - `Data_Valid` while not IDLE is ignored. It is neither queued nor able to corrupt the latched data.
- START: `TX_OUT`=0 for PRESCALE cycles, then go to DATA with `bit_cnt`=0.
- DATA
  - `TX_OUT` = latched data[`bit_cnt`], LSB first. Each bit is held PRESCALE cycles.
  - After bit DATA_WIDTH-1, go to PARITY if the latched `PAR_EN`=1, otherwise go to STOP.
- PARITY
  - The parity bit is XOR-reduce(latched data) XOR latched `PAR_TYP`.
  - With even parity, the data plus parity contain an even number of ones.
  - Hold the bit PRESCALE cycles, then go to STOP.
- STOP: `TX_OUT`=1 for PRESCALE cycles, then go to IDLE.
- Parity is computed from the latched copy only. Changes on `P_DATA`, `PAR_EN` or `PAR_TYP` mid-frame have no effect.
- Reset values:
  - state IDLE, `TX_OUT`=1, `Busy`=0;
  - `pre_cnt`=0, `bit_cnt`=0, data latch 0.
- Reset has priority over every other event.
  - `RST`=1 mid-frame aborts the frame.
  - `TX_OUT` is 1 and `Busy` is 0 from the cycle after the reset edge.
  - No partial frame resumes after reset.

## Timing
- `TX_OUT` and `Busy` are registered outputs, with no combinational path from inputs to outputs.
- Accept edge A is the rising edge where state = IDLE and `Data_Valid` = 1.
  - From the cycle after A: `TX_OUT`=0 (start bit) and `Busy`=1.
- Frame length N = 2 + DATA_WIDTH + PAR_EN bits, lasting N×PRESCALE cycles.
  - `Busy` is high for exactly N×PRESCALE cycles.
  - `TX_OUT` changes only at bit boundaries. There are no glitches inside a bit.
- After the last stop cycle the block spends at least one cycle in IDLE.
  - A new request is accepted in that cycle at the earliest.
  - Back-to-back period is N×PRESCALE+1 cycles, including one extra idle-high cycle.
- `Data_Valid` held high continuously sends the `P_DATA` value present at each accept edge, one frame per period.
- `Data_Valid` and `RST` both high on the same edge: reset wins and nothing is accepted.

## Test plan
- **Reset state.** Drive `RST`=1 for 2 cycles with `Data_Valid`=1 → `TX_OUT`=1 and `Busy`=0 throughout, and no start bit after reset is released while `Data_Valid`=0.
- **Even parity, PRESCALE=1.** Send `P_DATA`=0xA5 with `PAR_EN`=1 and `PAR_TYP`=0 → `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,0,1 (parity bit 0), `Busy` high for exactly 11 cycles, then IDLE.
- **Odd parity, no parity, PRESCALE=1.** Send `P_DATA`=0x01 with `PAR_EN`=1 and `PAR_TYP`=1 → parity bit 0. Send 0x03 with `PAR_EN`=0 → 10-bit frame 0,1,1,0,0,0,0,0,0,1 and `Busy` high for 10 cycles.
- **Bit timing, PRESCALE=4.** Send `P_DATA`=0x80 with `PAR_EN`=0 → each bit lasts exactly 4 cycles, the MSB high in cycles 32–35 after A, and `Busy` high for 40 cycles.
- **Busy ignore and back-to-back.** Pulse `Data_Valid` with 0xFF mid-frame while sending 0x00 → the transmitted data bits are all 0 and no extra frame follows. Hold `Data_Valid` high → the next start bit begins exactly 1 idle cycle after the stop bit.
- **Mid-frame reset.** Assert `RST` for 1 cycle during data bit 3 → `TX_OUT`=1 and `Busy`=0 the next cycle. A request issued afterwards produces a complete, correct frame.
